// File: rtl/mesi_isc_pkg.sv
// Shared command encodings and FSM state types for the MESI ISC CPU port.
package mesi_isc_pkg;

    localparam int unsigned MBUS_NOP      = 0;
    localparam int unsigned MBUS_WR       = 1;
    localparam int unsigned MBUS_RD       = 2;
    localparam int unsigned MBUS_WR_BROAD = 3;
    localparam int unsigned MBUS_RD_BROAD = 4;

    localparam int unsigned CBUS_NOP      = 0;
    localparam int unsigned CBUS_WR_SNOOP = 1;
    localparam int unsigned CBUS_RD_SNOOP = 2;
    localparam int unsigned CBUS_EN_WR    = 3;
    localparam int unsigned CBUS_EN_RD    = 4;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_ISSUE   = 2'd1,
        R_WAIT_EN = 2'd2,
        R_FINAL   = 2'd3
    } req_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_ACK   = 2'd2,
        S_HOLD  = 2'd3
    } snoop_state_t;

endpackage

// File: rtl/mesi_isc_snoop_resp.sv
// Coherence-bus responder: latches a snoop command, forwards it to the cache
// and acknowledges it after a programmable latency.
module mesi_isc_snoop_resp
    import mesi_isc_pkg::*;
#(
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LAT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr,
    input  logic [LAT_WIDTH-1:0]      snoop_lat,
    output logic                      cbus_ack,
    output logic                      snoop_valid,
    output logic [CBUS_CMD_WIDTH-1:0] snoop_cmd,
    output logic [ADDR_WIDTH-1:0]     snoop_addr,
    output logic                      en_wr_ack,
    output logic                      en_rd_ack
);

    localparam int unsigned CW = CBUS_CMD_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned LW = LAT_WIDTH;

    snoop_state_t   state, state_next;
    logic [LW-1:0]  cnt, cnt_next;
    logic [CW-1:0]  cmd_next;
    logic [AW-1:0]  addr_next;
    logic           valid_next;
    logic           ack_next;

    // Next-state logic; the counter is only loaded in S_IDLE so it never wraps.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = snoop_cmd;
        addr_next  = snoop_addr;
        valid_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (cbus_cmd != CW'(CBUS_NOP)) begin
                    cmd_next   = cbus_cmd;
                    addr_next  = cbus_addr;
                    cnt_next   = snoop_lat;
                    valid_next = (cbus_cmd == CW'(CBUS_WR_SNOOP)) ||
                                 (cbus_cmd == CW'(CBUS_RD_SNOOP));
                    state_next = (snoop_lat != LW'(0)) ? S_COUNT : S_ACK;
                end
            end
            S_COUNT: begin
                if (cnt == LW'(1)) begin
                    state_next = S_ACK;
                end else begin
                    cnt_next = cnt - LW'(1);
                end
            end
            S_ACK: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (cbus_cmd == CW'(CBUS_NOP)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        ack_next = (state_next == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            cbus_ack    <= 1'b0;
            snoop_valid <= 1'b0;
            snoop_cmd   <= CW'(CBUS_NOP);
            snoop_addr  <= '0;
            en_wr_ack   <= 1'b0;
            en_rd_ack   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cbus_ack    <= ack_next;
            snoop_valid <= valid_next;
            snoop_cmd   <= cmd_next;
            snoop_addr  <= addr_next;
            en_wr_ack   <= ack_next && (cmd_next == CW'(CBUS_EN_WR));
            en_rd_ack   <= ack_next && (cmd_next == CW'(CBUS_EN_RD));
        end
    end

endmodule

// File: rtl/mesi_isc_cpu_port_ctrl.sv
// Per-CPU port controller: sequences main-bus requests (including the
// broadcast enable handshake) and hosts the coherence-bus snoop responder.
module mesi_isc_cpu_port_ctrl
    import mesi_isc_pkg::*;
#(
    parameter int unsigned MBUS_CMD_WIDTH = 3,
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LAT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    input  logic [MBUS_CMD_WIDTH-1:0] req_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    output logic                      req_ready_o,
    output logic                      done_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    input  logic [LAT_WIDTH-1:0]      snoop_lat_i,
    output logic                      snoop_valid_o,
    output logic [CBUS_CMD_WIDTH-1:0] snoop_cmd_o,
    output logic [ADDR_WIDTH-1:0]     snoop_addr_o,
    output logic                      err_o
);

    localparam int unsigned MW = MBUS_CMD_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;

    req_state_t     state, state_next;
    logic [MW-1:0]  cmd_q, cmd_next;
    logic [AW-1:0]  addr_q, addr_next;
    logic [MW-1:0]  mbus_cmd_next;
    logic [AW-1:0]  mbus_addr_next;
    logic           done_next;
    logic           err_set;
    logic           req_illegal;
    logic           en_match;
    logic           en_wr_ack;
    logic           en_rd_ack;

    mesi_isc_snoop_resp #(
        .CBUS_CMD_WIDTH (CBUS_CMD_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .LAT_WIDTH      (LAT_WIDTH)
    ) u_snoop_resp (
        .clk         (clk),
        .rst         (rst),
        .cbus_cmd    (cbus_cmd_i),
        .cbus_addr   (cbus_addr_i),
        .snoop_lat   (snoop_lat_i),
        .cbus_ack    (cbus_ack_o),
        .snoop_valid (snoop_valid_o),
        .snoop_cmd   (snoop_cmd_o),
        .snoop_addr  (snoop_addr_o),
        .en_wr_ack   (en_wr_ack),
        .en_rd_ack   (en_rd_ack)
    );

    // Request sequencing; bus outputs are derived from the next state so they
    // appear one cycle after the decision.
    always_comb begin
        state_next     = state;
        cmd_next       = cmd_q;
        addr_next      = addr_q;
        mbus_cmd_next  = MW'(MBUS_NOP);
        mbus_addr_next = '0;
        done_next      = 1'b0;
        err_set        = 1'b0;
        req_illegal    = (req_cmd_i == MW'(MBUS_NOP)) || (req_cmd_i > MW'(MBUS_RD_BROAD));
        en_match       = (en_wr_ack && (cmd_q == MW'(MBUS_WR_BROAD))) ||
                         (en_rd_ack && (cmd_q == MW'(MBUS_RD_BROAD)));
        case (state)
            R_IDLE: begin
                if (mbus_ack_i) begin
                    err_set = 1'b1;
                end
                if (req_valid_i) begin
                    if (req_illegal) begin
                        err_set = 1'b1;
                    end else begin
                        cmd_next   = req_cmd_i;
                        addr_next  = req_addr_i;
                        state_next = R_ISSUE;
                    end
                end
            end
            R_ISSUE: begin
                if (mbus_ack_i) begin
                    if ((cmd_q == MW'(MBUS_WR)) || (cmd_q == MW'(MBUS_RD))) begin
                        done_next  = 1'b1;
                        state_next = R_IDLE;
                    end else begin
                        state_next = R_WAIT_EN;
                    end
                end
            end
            R_WAIT_EN: begin
                if (mbus_ack_i) begin
                    err_set = 1'b1;
                end
                if (en_match) begin
                    cmd_next   = (cmd_q == MW'(MBUS_WR_BROAD)) ? MW'(MBUS_WR) : MW'(MBUS_RD);
                    state_next = R_FINAL;
                end
            end
            R_FINAL: begin
                if (mbus_ack_i) begin
                    done_next  = 1'b1;
                    state_next = R_IDLE;
                end
            end
            default: begin
                state_next = R_IDLE;
            end
        endcase
        // An enable that does not release a waiting broadcast is a protocol error.
        if ((en_wr_ack || en_rd_ack) && !((state == R_WAIT_EN) && en_match)) begin
            err_set = 1'b1;
        end
        if ((state_next == R_ISSUE) || (state_next == R_FINAL)) begin
            mbus_cmd_next  = cmd_next;
            mbus_addr_next = addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= R_IDLE;
            cmd_q       <= MW'(MBUS_NOP);
            addr_q      <= '0;
            req_ready_o <= 1'b1;
            done_o      <= 1'b0;
            mbus_cmd_o  <= MW'(MBUS_NOP);
            mbus_addr_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_q       <= cmd_next;
            addr_q      <= addr_next;
            req_ready_o <= (state_next == R_IDLE);
            done_o      <= done_next;
            mbus_cmd_o  <= mbus_cmd_next;
            mbus_addr_o <= mbus_addr_next;
            err_o       <= err_o | err_set;
        end
    end

endmodule

// File: tb/tb_mesi_isc_cpu_port_ctrl.sv
// Directed, table-driven bench for the MESI ISC CPU port controller.
module tb_mesi_isc_cpu_port_ctrl;

    localparam logic [2:0] MNOP = 3'd0, MWR = 3'd1, MRD = 3'd2, MWRB = 3'd3, MRDB = 3'd4;
    localparam logic [2:0] CNOP = 3'd0, CWRS = 3'd1, CRDS = 3'd2, CENWR = 3'd3, CENRD = 3'd4;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [2:0]  rcmd;
        logic [31:0] raddr;
        logic        mack;
        logic [2:0]  ccmd;
        logic [31:0] caddr;
        logic [3:0]  lat;
        logic        e_ready;
        logic        e_done;
        logic [2:0]  e_mcmd;
        logic [31:0] e_maddr;
        logic        e_cack;
        logic        e_sval;
        logic [2:0]  e_scmd;
        logic [31:0] e_saddr;
        logic        e_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic [2:0]  req_cmd_i;
    logic [31:0] req_addr_i;
    logic        req_ready_o;
    logic        done_o;
    logic [2:0]  mbus_cmd_o;
    logic [31:0] mbus_addr_o;
    logic        mbus_ack_i;
    logic [2:0]  cbus_cmd_i;
    logic [31:0] cbus_addr_i;
    logic        cbus_ack_o;
    logic [3:0]  snoop_lat_i;
    logic        snoop_valid_o;
    logic [2:0]  snoop_cmd_o;
    logic [31:0] snoop_addr_o;
    logic        err_o;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl[$];

    mesi_isc_cpu_port_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_cmd_i     (req_cmd_i),
        .req_addr_i    (req_addr_i),
        .req_ready_o   (req_ready_o),
        .done_o        (done_o),
        .mbus_cmd_o    (mbus_cmd_o),
        .mbus_addr_o   (mbus_addr_o),
        .mbus_ack_i    (mbus_ack_i),
        .cbus_cmd_i    (cbus_cmd_i),
        .cbus_addr_i   (cbus_addr_i),
        .cbus_ack_o    (cbus_ack_o),
        .snoop_lat_i   (snoop_lat_i),
        .snoop_valid_o (snoop_valid_o),
        .snoop_cmd_o   (snoop_cmd_o),
        .snoop_addr_o  (snoop_addr_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic rv, input logic [2:0] rc, input logic [31:0] ra,
        input logic ma, input logic [2:0] cc, input logic [31:0] ca, input logic [3:0] lt,
        input logic e_rdy, input logic e_dn, input logic [2:0] e_mc, input logic [31:0] e_ma,
        input logic e_ca, input logic e_sv, input logic [2:0] e_sc, input logic [31:0] e_sa,
        input logic e_er);
        vec_t v;
        v.rst = r;  v.rv = rv; v.rcmd = rc; v.raddr = ra; v.mack = ma;
        v.ccmd = cc; v.caddr = ca; v.lat = lt;
        v.e_ready = e_rdy; v.e_done = e_dn; v.e_mcmd = e_mc; v.e_maddr = e_ma;
        v.e_cack = e_ca; v.e_sval = e_sv; v.e_scmd = e_sc; v.e_saddr = e_sa; v.e_err = e_er;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, check outputs at the next falling edge.
    task automatic apply(input vec_t v, input string tag, input int id);
        logic [74:0] got, exp;
        rst         = v.rst;
        req_valid_i = v.rv;
        req_cmd_i   = v.rcmd;
        req_addr_i  = v.raddr;
        mbus_ack_i  = v.mack;
        cbus_cmd_i  = v.ccmd;
        cbus_addr_i = v.caddr;
        snoop_lat_i = v.lat;
        @(posedge clk);
        @(negedge clk);
        got = {req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o,
               snoop_valid_o, snoop_cmd_o, snoop_addr_o, err_o};
        exp = {v.e_ready, v.e_done, v.e_mcmd, v.e_maddr, v.e_cack,
               v.e_sval, v.e_scmd, v.e_saddr, v.e_err};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got rdy=%b done=%b mcmd=%0d maddr=%h cack=%b sval=%b scmd=%0d saddr=%h err=%b | exp rdy=%b done=%b mcmd=%0d maddr=%h cack=%b sval=%b scmd=%0d saddr=%h err=%b",
                     tag, id, req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o,
                     snoop_valid_o, snoop_cmd_o, snoop_addr_o, err_o,
                     v.e_ready, v.e_done, v.e_mcmd, v.e_maddr, v.e_cack,
                     v.e_sval, v.e_scmd, v.e_saddr, v.e_err);
        end
    endtask

    initial begin
        rst = 1'b0; req_valid_i = 1'b0; req_cmd_i = '0; req_addr_i = '0;
        mbus_ack_i = 1'b0; cbus_cmd_i = '0; cbus_addr_i = '0; snoop_lat_i = '0;

        // reset
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // RD 0x1000, ack on third issue cycle
        tbl.push_back(mk(1,1,MRD,32'h1000,0, CNOP,0,0, 0,0,MRD,32'h1000,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 0,0,MRD,32'h1000,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 0,0,MRD,32'h1000,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 1,1,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // WR_BROAD 0x2000 with EN_WR at latency 2
        tbl.push_back(mk(1,1,MWRB,32'h2000,0, CNOP,0,0, 0,0,MWRB,32'h2000,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 0,0,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CENWR,32'h2000,2, 0,0,MNOP,0,0,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CENWR,32'h2000,2, 0,0,MNOP,0,0,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CENWR,32'h2000,2, 0,0,MNOP,0,1,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,2, 0,0,MWR,32'h2000,0,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,2, 0,0,MWR,32'h2000,0,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,2, 1,1,MNOP,0,0,0,CENWR,32'h2000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CENWR,32'h2000,0));
        // RD_SNOOP 0xABC0 latency 0; held command is not re-detected
        tbl.push_back(mk(1,0,MNOP,0,0, CRDS,32'hABC0,0, 1,0,MNOP,0,1,1,CRDS,32'hABC0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CRDS,32'hABC0,0, 1,0,MNOP,0,0,0,CRDS,32'hABC0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CRDS,32'hABC0,0, 1,0,MNOP,0,0,0,CRDS,32'hABC0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CRDS,32'hABC0,0));
        // EN_RD while waiting for EN_WR
        tbl.push_back(mk(1,1,MWRB,32'h3000,0, CNOP,0,0, 0,0,MWRB,32'h3000,0,0,CRDS,32'hABC0,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 0,0,MNOP,0,0,0,CRDS,32'hABC0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CENRD,32'h3000,0, 0,0,MNOP,0,1,0,CENRD,32'h3000,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 0,0,MNOP,0,0,0,CENRD,32'h3000,1));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 0,0,MNOP,0,0,0,CENRD,32'h3000,1));
        // reset in R_WAIT_EN
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // illegal request command
        tbl.push_back(mk(1,1,3'd5,32'h44,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,1));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,1));
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // stray main-bus ack while idle
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,1));
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // EN_WR with no outstanding request
        tbl.push_back(mk(1,0,MNOP,0,0, CENWR,32'h55,0, 1,0,MNOP,0,1,0,CENWR,32'h55,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CENWR,32'h55,1));
        tbl.push_back(mk(0,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));
        // immediate acks and back-to-back requests
        tbl.push_back(mk(1,1,MWR,32'h10,0, CNOP,0,0, 0,0,MWR,32'h10,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 1,1,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(1,1,MRD,32'h20,0, CNOP,0,0, 0,0,MRD,32'h20,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,1, CNOP,0,0, 1,1,MNOP,0,0,0,CNOP,0,0));
        tbl.push_back(mk(1,0,MNOP,0,0, CNOP,0,0, 1,0,MNOP,0,0,0,CNOP,0,0));

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i], "tbl", i);

        // Max latency RD_SNOOP during R_ISSUE; cbus command changes mid-count
        // and mbus_ack lands in the cbus_ack_o cycle.
        for (int i = 0; i <= 17; i++) begin
            vec_t v;
            logic [2:0]  cc;
            logic [31:0] ca;
            cc = (i >= 5) ? CWRS : CRDS;
            ca = (i >= 5) ? 32'h1111 : 32'hBEEF;
            if (i >= 16) begin
                cc = CNOP;
                ca = 32'h0;
            end
            v = mk(1, (i == 0), (i == 0) ? MRD : MNOP, (i == 0) ? 32'h4000 : 32'h0,
                   (i == 16), cc, ca, 4'd15,
                   (i >= 16), (i == 16), (i < 16) ? MRD : MNOP, (i < 16) ? 32'h4000 : 32'h0,
                   (i == 15), (i == 0), CRDS, 32'hBEEF, 1'b0);
            apply(v, "lat15", i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
